// File: rtl/riscv_pkg.sv
// Shared types for the execute stage: ALU op codes, control-word layout,
// branch/length encodings and the mul/div sequencer types.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17,
    ALU_PASSB  = 5'd18
  } aluop_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6,
    BR_JAL  = 3'd7
  } branch_e;

  typedef enum logic [1:0] {
    LEN_WORD = 2'd0,
    LEN_BYTE = 2'd1,
    LEN_HALF = 2'd2
  } length_e;

  // Field layout of the 10-bit control word, MSB first.
  typedef struct packed {
    logic    regwrite;
    logic    memread;
    logic    memwrite;
    length_e length;
    logic    sign;
    branch_e branch;
    logic    memtoreg;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // What the mul/div sequencer hands back once its 32 iterations finish.
  typedef enum logic [1:0] {
    MD_MUL_LO,
    MD_MUL_HI,
    MD_DIV_Q,
    MD_DIV_R
  } md_kind_e;

  typedef enum logic {
    MD_IDLE,
    MD_RUN
  } md_state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Upstream/downstream signal bundle of the execute stage. The master side
// is the decode stage driving an instruction in; the slave side is the
// execute stage presenting its EX/MEM register to the memory stage.
interface execute_stage_if;
  import riscv_pkg::*;

  logic              flush;
  logic              in_valid;
  logic [4:0]        aluop;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [XLEN-1:0]   in_wdata;
  logic [4:0]        in_rd;
  logic [CTRL_W-1:0] in_ctrl;

  logic              stall;
  logic              out_valid;
  logic [XLEN-1:0]   result;
  logic              zero;
  logic              neg;
  logic [XLEN-1:0]   out_wdata;
  logic [4:0]        out_rd;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output flush, in_valid, aluop, op_a, op_b, in_wdata, in_rd, in_ctrl,
    input  stall, out_valid, result, zero, neg, out_wdata, out_rd, out_ctrl
  );

  modport slave (
    input  flush, in_valid, aluop, op_a, op_b, in_wdata, in_rd, in_ctrl,
    output stall, out_valid, result, zero, neg, out_wdata, out_rd, out_ctrl
  );

endinterface

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiplier/divider. Works on operand magnitudes: 32
// shift-add (mul) or restoring shift-subtract (div) steps, then a sign
// fix-up on the final step. Latency is fixed at 32 RUN cycles, including
// divide-by-zero.
module muldiv_iter
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  md_state_e       state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [63:0]     acc_q, acc_d;
  logic [31:0]     mcand_q, mcand_d;
  md_kind_e        kind_q, kind_d;
  logic            neg_q, neg_d;
  logic            div0_q, div0_d;

  logic            a_signed, b_signed;
  md_kind_e        kind_in;
  logic            a_neg, b_neg, b_zero;
  logic [31:0]     a_mag, b_mag;
  logic            start_neg;

  logic [32:0]     mul_sum;
  logic [63:0]     mul_next;
  logic [32:0]     rem_sh;
  logic [32:0]     div_diff;
  logic [63:0]     div_next;
  logic [63:0]     acc_step;
  logic [63:0]     prod_fix;

  // Decode operand signedness and result selection for the incoming op.
  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    kind_in  = MD_MUL_LO;
    case (op_i)
      ALU_MUL:    begin a_signed = 1'b1; b_signed = 1'b1; kind_in = MD_MUL_LO; end
      ALU_MULH:   begin a_signed = 1'b1; b_signed = 1'b1; kind_in = MD_MUL_HI; end
      ALU_MULHSU: begin a_signed = 1'b1;                  kind_in = MD_MUL_HI; end
      ALU_MULHU:  begin                                   kind_in = MD_MUL_HI; end
      ALU_DIV:    begin a_signed = 1'b1; b_signed = 1'b1; kind_in = MD_DIV_Q;  end
      ALU_DIVU:   begin                                   kind_in = MD_DIV_Q;  end
      ALU_REM:    begin a_signed = 1'b1; b_signed = 1'b1; kind_in = MD_DIV_R;  end
      ALU_REMU:   begin                                   kind_in = MD_DIV_R;  end
      default:    ;
    endcase
  end

  assign a_neg  = a_signed & a_i[31];
  assign b_neg  = b_signed & b_i[31];
  assign a_mag  = a_neg ? (~a_i + 32'd1) : a_i;
  assign b_mag  = b_neg ? (~b_i + 32'd1) : b_i;
  assign b_zero = (b_i == 32'd0);

  // Sign of the final result: remainder follows the dividend; a quotient
  // by zero is forced to all-ones, so it never gets negated.
  always_comb begin
    start_neg = a_neg ^ b_neg;
    case (kind_in)
      MD_DIV_Q: start_neg = (a_neg ^ b_neg) & ~b_zero;
      MD_DIV_R: start_neg = a_neg;
      default:  ;
    endcase
  end

  // One iteration step of either algorithm on the current accumulator.
  always_comb begin
    // Multiply: {hi,lo}, lo holds the multiplier; add and shift right.
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    // Divide: {rem,quo}, shift left one and try subtracting the divisor.
    rem_sh   = acc_q[63:31];
    div_diff = rem_sh - {1'b0, mcand_q};
    div_next = div_diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                            : {div_diff[31:0], acc_q[30:0], 1'b1};
    acc_step = (kind_q == MD_MUL_LO || kind_q == MD_MUL_HI) ? mul_next : div_next;
  end

  // Sign fix-up and result selection applied to the last iteration.
  always_comb begin
    prod_fix = neg_q ? (~acc_step + 64'd1) : acc_step;
    result_o = prod_fix[31:0];
    case (kind_q)
      MD_MUL_LO: result_o = prod_fix[31:0];
      MD_MUL_HI: result_o = prod_fix[63:32];
      MD_DIV_Q:  result_o = div0_q ? 32'hFFFF_FFFF
                          : (neg_q ? (~acc_step[31:0] + 32'd1) : acc_step[31:0]);
      MD_DIV_R:  result_o = neg_q ? (~acc_step[63:32] + 32'd1) : acc_step[63:32];
      default:   ;
    endcase
  end

  // Next-state logic for the IDLE/RUN sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    kind_d  = kind_q;
    neg_d   = neg_q;
    div0_d  = div0_q;
    done_o  = 1'b0;
    busy_o  = (state_q == MD_RUN);
    case (state_q)
      MD_IDLE: begin
        if (start_i && !flush_i) begin
          state_d = MD_RUN;
          cnt_d   = 5'd0;
          kind_d  = kind_in;
          neg_d   = start_neg;
          div0_d  = b_zero & (kind_in == MD_DIV_Q);
          if (kind_in == MD_MUL_LO || kind_in == MD_MUL_HI) begin
            acc_d   = {32'd0, b_mag};
            mcand_d = a_mag;
          end else begin
            acc_d   = {32'd0, a_mag};
            mcand_d = b_mag;
          end
        end
      end
      MD_RUN: begin
        if (flush_i) begin
          state_d = MD_IDLE;
          cnt_d   = 5'd0;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = MD_IDLE;
            done_o  = 1'b1;
          end
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // Sequencer state register with synchronous reset.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: datapath registers are reset too; the block is small and a
      // known state after reset keeps the outputs deterministic.
      state_q <= MD_IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 64'd0;
      mcand_q <= 32'd0;
      kind_q  <= MD_MUL_LO;
      neg_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      kind_q  <= kind_d;
      neg_q   <= neg_d;
      div0_q  <= div0_d;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU, iterative mul/div, and the registered
// EX/MEM slot feeding the memory stage. Flush and reset kill the slot;
// mul/div stalls upstream while it runs.
module execute_stage
  import riscv_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  execute_stage_if.slave   ex
);

  logic [XLEN-1:0]   alu_res;
  logic              alu_neg;
  logic [4:0]        shamt;

  logic              md_busy, md_done;
  logic [XLEN-1:0]   md_res;
  logic              accept, in_is_md;

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [XLEN-1:0]   pend_wdata_q, pend_wdata_d;
  logic [4:0]        pend_rd_q, pend_rd_d;
  logic [CTRL_W-1:0] pend_ctrl_q, pend_ctrl_d;

  assign shamt    = ex.op_b[4:0];
  assign in_is_md = is_muldiv(ex.aluop);
  assign accept   = ex.in_valid & ~md_busy & ~ex.flush;

  muldiv_iter u_muldiv (
    .clk      (clk),
    .resetn   (resetn),
    .flush_i  (ex.flush),
    .start_i  (accept & in_is_md),
    .op_i     (ex.aluop),
    .a_i      (ex.op_a),
    .b_i      (ex.op_b),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_res)
  );

  // Single-cycle ALU; undefined codes produce zero.
  always_comb begin
    alu_res = '0;
    case (ex.aluop)
      ALU_ADD:   alu_res = ex.op_a + ex.op_b;
      ALU_SUB:   alu_res = ex.op_a - ex.op_b;
      ALU_AND:   alu_res = ex.op_a & ex.op_b;
      ALU_OR:    alu_res = ex.op_a | ex.op_b;
      ALU_XOR:   alu_res = ex.op_a ^ ex.op_b;
      ALU_SLL:   alu_res = ex.op_a << shamt;
      ALU_SRL:   alu_res = ex.op_a >> shamt;
      ALU_SRA:   alu_res = 32'($signed(ex.op_a) >>> shamt);
      ALU_SLT:   alu_res = {31'd0, $signed(ex.op_a) < $signed(ex.op_b)};
      ALU_SLTU:  alu_res = {31'd0, ex.op_a < ex.op_b};
      ALU_PASSB: alu_res = ex.op_b;
      default:   alu_res = '0;
    endcase
    // For set-less-than the branch unit wants the comparison bit itself.
    alu_neg = (ex.aluop == ALU_SLT || ex.aluop == ALU_SLTU) ? alu_res[0] : alu_res[31];
  end

  // EX/MEM slot next state: flush, then mul/div completion, then a
  // single-cycle accept; anything else is a bubble.
  always_comb begin
    valid_d      = 1'b0;
    result_d     = result_q;
    zero_d       = zero_q;
    neg_d        = neg_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    ctrl_d       = ctrl_q;
    pend_wdata_d = pend_wdata_q;
    pend_rd_d    = pend_rd_q;
    pend_ctrl_d  = pend_ctrl_q;
    if (ex.flush) begin
      valid_d = 1'b0;
    end else if (md_done) begin
      valid_d  = 1'b1;
      result_d = md_res;
      zero_d   = (md_res == '0);
      neg_d    = md_res[31];
      wdata_d  = pend_wdata_q;
      rd_d     = pend_rd_q;
      ctrl_d   = pend_ctrl_q;
    end else if (accept && !in_is_md) begin
      valid_d  = 1'b1;
      result_d = alu_res;
      zero_d   = (alu_res == '0);
      neg_d    = alu_neg;
      wdata_d  = ex.in_wdata;
      rd_d     = ex.in_rd;
      ctrl_d   = ex.in_ctrl;
    end else if (accept) begin
      // Mul/div start: park the pass-through fields until the result lands.
      pend_wdata_d = ex.in_wdata;
      pend_rd_d    = ex.in_rd;
      pend_ctrl_d  = ex.in_ctrl;
    end
  end

  // EX/MEM registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q      <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      neg_q        <= 1'b0;
      wdata_q      <= '0;
      rd_q         <= '0;
      ctrl_q       <= '0;
      pend_wdata_q <= '0;
      pend_rd_q    <= '0;
      pend_ctrl_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      neg_q        <= neg_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      ctrl_q       <= ctrl_d;
      pend_wdata_q <= pend_wdata_d;
      pend_rd_q    <= pend_rd_d;
      pend_ctrl_q  <= pend_ctrl_d;
    end
  end

  assign ex.stall     = md_busy;
  assign ex.out_valid = valid_q;
  assign ex.result    = result_q;
  assign ex.zero      = zero_q;
  assign ex.neg       = neg_q;
  assign ex.out_wdata = wdata_q;
  assign ex.out_rd    = rd_q;
  assign ex.out_ctrl  = ctrl_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: reset, single-cycle ALU ops, iterative
// mul/div including divide-by-zero and overflow, flush and mid-run reset.
module tb_execute_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  execute_stage_if ex ();

  execute_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .ex     (ex)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_res"},   ex.result, 32'd0);
    check({tag, "_wdata"}, ex.out_wdata, 32'd0);
    check({tag, "_misc"},
          {17'd0, ex.out_valid, ex.zero, ex.neg, ex.stall, ex.out_rd, ex.out_ctrl}, 32'd0);
  endtask

  // Single-cycle op; leaves in_valid high so successive calls are back-to-back.
  task automatic alu_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_neg);
    ex.in_valid = 1'b1;
    ex.aluop    = op;
    ex.op_a     = a;
    ex.op_b     = b;
    tick();
    check({tag, "_res"},   ex.result, exp_res);
    check({tag, "_flags"}, {29'd0, ex.out_valid, ex.zero, ex.neg}, {29'd0, 1'b1, exp_zero, exp_neg});
  endtask

  // Multi-cycle op; upstream keeps pushing a different instruction during RUN.
  task automatic md_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res);
    int n;
    int vbad;
    ex.in_valid = 1'b1;
    ex.aluop    = op;
    ex.op_a     = a;
    ex.op_b     = b;
    ex.in_wdata = 32'h600D_F00D;
    ex.in_rd    = 5'd19;
    ex.in_ctrl  = 10'h155;
    tick();
    check({tag, "_v0"}, {31'd0, ex.out_valid}, 32'd0);
    ex.aluop    = ALU_ADD;
    ex.op_a     = 32'hA5A5_A5A5;
    ex.op_b     = 32'h5A5A_5A5A;
    ex.in_wdata = 32'd0;
    ex.in_rd    = 5'd2;
    ex.in_ctrl  = 10'd0;
    n    = 0;
    vbad = 0;
    while (ex.stall && n < 40) begin
      n++;
      if (ex.out_valid) vbad++;
      tick();
    end
    ex.in_valid = 1'b0;
    check({tag, "_stall"}, n, 32);
    check({tag, "_vrun"},  vbad, 0);
    check({tag, "_valid"}, {31'd0, ex.out_valid}, 32'd1);
    check({tag, "_res"},   ex.result, exp_res);
    check({tag, "_pass"},  {17'd0, ex.out_rd, ex.out_ctrl}, {17'd0, 5'd19, 10'h155});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nv;
    int ns;
    ex.flush    = 1'b0;
    ex.in_valid = 1'b0;
    ex.aluop    = ALU_ADD;
    ex.op_a     = '0;
    ex.op_b     = '0;
    ex.in_wdata = '0;
    ex.in_rd    = '0;
    ex.in_ctrl  = '0;
    resetn      = 1'b0;
    repeat (2) tick();
    check_cleared("reset");
    resetn = 1'b1;

    // ADD with negative result and pass-through fields.
    ex.in_valid = 1'b1;
    ex.aluop    = ALU_ADD;
    ex.op_a     = 32'd5;
    ex.op_b     = 32'hFFFF_FFF9;
    ex.in_wdata = 32'hCAFE_0001;
    ex.in_rd    = 5'd7;
    ex.in_ctrl  = 10'h2A5;
    #1;
    check("add_stall_pre", {31'd0, ex.stall}, 32'd0);
    tick();
    check("add_res",   ex.result, 32'hFFFF_FFFE);
    check("add_flags", {29'd0, ex.out_valid, ex.zero, ex.neg}, 32'b101);
    check("add_wdata", ex.out_wdata, 32'hCAFE_0001);
    check("add_rdctl", {17'd0, ex.out_rd, ex.out_ctrl}, {17'd0, 5'd7, 10'h2A5});
    check("add_stall", {31'd0, ex.stall}, 32'd0);
    ex.in_valid = 1'b0;
    tick();
    check("bubble_valid", {31'd0, ex.out_valid}, 32'd0);
    check("bubble_hold",  ex.result, 32'hFFFF_FFFE);

    // Back-to-back single-cycle ops.
    alu_op("sltu",  ALU_SLTU,  32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0, 1'b1);
    alu_op("sub",   ALU_SUB,   32'd7,         32'd7,         32'd0,         1'b1, 1'b0);
    alu_op("sra",   ALU_SRA,   32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1'b1);
    alu_op("srl",   ALU_SRL,   32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1'b0);
    alu_op("sll",   ALU_SLL,   32'd1,         32'h0000_003F, 32'h8000_0000, 1'b0, 1'b1);
    alu_op("slt",   ALU_SLT,   32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b1);
    alu_op("xor",   ALU_XOR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0);
    alu_op("passb", ALU_PASSB, 32'd0,         32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
    alu_op("undef", 5'd25,     32'd3,         32'd4,         32'd0,         1'b1, 1'b0);
    ex.in_valid = 1'b0;
    tick();

    // Iterative mul/div.
    md_op("div_neg", ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    check("div_neg_flags", {30'd0, ex.zero, ex.neg}, 32'b01);
    md_op("rem_neg", ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    md_op("divu_z",  ALU_DIVU,   32'h0000_0055, 32'd0,         32'hFFFF_FFFF);
    md_op("div_nz",  ALU_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
    md_op("rem_z",   ALU_REM,    32'h0000_1234, 32'd0,         32'h0000_1234);
    md_op("div_ovf", ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    md_op("rem_ovf", ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    check("rem_ovf_zero", {31'd0, ex.zero}, 32'd1);
    md_op("divu",    ALU_DIVU,   32'd100,       32'd7,         32'd14);
    md_op("remu",    ALU_REMU,   32'd100,       32'd7,         32'd2);
    md_op("mulhu",   ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    md_op("mulh",    ALU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    md_op("mul",     ALU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    md_op("mulhsu",  ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    md_op("mul_big", ALU_MUL,    32'h0001_0003, 32'h0000_0007, 32'h0007_0015);
    tick();

    // Flush in RUN cycle 10, with a competing instruction offered at that edge.
    ex.in_valid = 1'b1;
    ex.aluop    = ALU_DIV;
    ex.op_a     = 32'd100;
    ex.op_b     = 32'd7;
    tick();
    ex.in_valid = 1'b0;
    repeat (9) tick();
    check("flush_pre_stall", {31'd0, ex.stall}, 32'd1);
    ex.flush    = 1'b1;
    ex.in_valid = 1'b1;
    ex.aluop    = ALU_ADD;
    ex.op_a     = 32'd1;
    ex.op_b     = 32'd1;
    tick();
    ex.flush    = 1'b0;
    ex.in_valid = 1'b0;
    check("flush_stall", {31'd0, ex.stall}, 32'd0);
    check("flush_valid", {31'd0, ex.out_valid}, 32'd0);
    nv = 0;
    ns = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ex.out_valid) nv++;
      if (ex.stall) ns++;
    end
    check("flush_after_valid", nv, 0);
    check("flush_after_stall", ns, 0);

    // Make the outputs non-zero, then reset 20 cycles into a MUL.
    ex.in_wdata = 32'h1111_2222;
    ex.in_rd    = 5'd9;
    ex.in_ctrl  = 10'h3FF;
    alu_op("pre_rst", ALU_OR, 32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1'b0, 1'b0);
    ex.aluop    = ALU_MUL;
    ex.op_a     = 32'd3;
    ex.op_b     = 32'd5;
    tick();
    ex.in_valid = 1'b0;
    repeat (19) tick();
    check("rst_pre_stall", {31'd0, ex.stall}, 32'd1);
    resetn = 1'b0;
    tick();
    check_cleared("rst_mid");
    resetn = 1'b1;
    tick();
    check("rst_post_idle", {30'd0, ex.stall, ex.out_valid}, 32'd0);
    alu_op("post_rst", ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
    ex.in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
